// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared constants, FSM state types and helpers for the motor-controller register file.
package mc_ctrl_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned STRB_W      = DATA_W / 8;
  localparam int unsigned IDX_W       = 3;
  localparam int unsigned NUM_RW_REGS = 4;

  // Word offsets of the register map (AxADDR[4:2])
  localparam logic [IDX_W-1:0] REG_CTRL    = 3'd0;
  localparam logic [IDX_W-1:0] REG_TARGET  = 3'd1;
  localparam logic [IDX_W-1:0] REG_PERIOD  = 3'd2;
  localparam logic [IDX_W-1:0] REG_ACCEL   = 3'd3;
  localparam logic [IDX_W-1:0] REG_STATUS  = 3'd4;
  localparam logic [IDX_W-1:0] REG_VERSION = 3'd5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WAIT = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } r_state_t;

  // True for the four read/write control registers
  function automatic logic is_rw(input logic [IDX_W-1:0] idx);
    return idx < IDX_W'(NUM_RW_REGS);
  endfunction

  // True for every decoded word (RW and RO)
  function automatic logic is_mapped(input logic [IDX_W-1:0] idx);
    return idx <= REG_VERSION;
  endfunction

  // Replace only the byte lanes selected by strb
  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_word,
                                                    input logic [DATA_W-1:0] new_word,
                                                    input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int unsigned b = 0; b < STRB_W; b++) begin
      if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mc_ctrl_axil_regs.sv
// mc_ctrl_axil_regs: AXI4-Lite slave with four RW control registers, STATUS and VERSION.
// Build option: define MC_CTRL_WSTRB_EN to apply WSTRB byte lanes to RW register writes;
// without it every write replaces the full 32-bit word.
module mc_ctrl_axil_regs
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
  parameter logic [31:0] VERSION            = 32'h0001_0000
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     status_i,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     ctrl_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     target_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     period_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     accel_o,
  output logic [3:0]                        reg_wr_o
);

  // Write channel state
  w_state_t                         w_state, w_state_d;
  logic                             aw_held, aw_held_d;
  logic                             w_held, w_held_d;
  logic [IDX_W-1:0]                 waddr_idx, waddr_idx_d;
  logic [DATA_W-1:0]                wdata_q, wdata_d;
  logic [STRB_W-1:0]                wstrb_q, wstrb_d;
  logic                             awready, awready_d;
  logic                             wready, wready_d;
  logic                             bvalid, bvalid_d;
  logic [1:0]                       bresp, bresp_d;
  logic [NUM_RW_REGS-1:0]           reg_wr, reg_wr_d;
  logic [NUM_RW_REGS-1:0][DATA_W-1:0] regs, regs_d;
  logic                             aw_hs, w_hs;
  logic [DATA_W-1:0]                wr_word;

  // Read channel state
  r_state_t                         r_state, r_state_d;
  logic                             arready, arready_d;
  logic                             rvalid, rvalid_d;
  logic [DATA_W-1:0]                rdata, rdata_d;
  logic [1:0]                       rresp, rresp_d;
  logic                             ar_hs;
  logic [IDX_W-1:0]                 ar_idx;

  // Value a pending write would leave in its target RW register
  always_comb begin
    wr_word = wdata_q;
`ifdef MC_CTRL_WSTRB_EN
    wr_word = merge_bytes(regs[waddr_idx[1:0]], wdata_q, wstrb_q);
`endif
  end

  // Write FSM: collect AW and W in any order, commit one cycle later, then hold B
  always_comb begin
    w_state_d   = w_state;
    aw_held_d   = aw_held;
    w_held_d    = w_held;
    waddr_idx_d = waddr_idx;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    bvalid_d    = bvalid;
    bresp_d     = bresp;
    reg_wr_d    = '0;
    regs_d      = regs;
    aw_hs       = S_AXI_AWVALID && awready;
    w_hs        = S_AXI_WVALID && wready;

    case (w_state)
      W_IDLE, W_WAIT: begin
        if (aw_held && w_held) begin
          if (is_rw(waddr_idx)) begin
            regs_d[waddr_idx[1:0]]   = wr_word;
            reg_wr_d[waddr_idx[1:0]] = 1'b1;
          end
          bresp_d   = is_mapped(waddr_idx) ? RESP_OKAY : RESP_SLVERR;
          bvalid_d  = 1'b1;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          w_state_d = W_RESP;
        end else begin
          if (aw_hs) begin
            aw_held_d   = 1'b1;
            waddr_idx_d = S_AXI_AWADDR[4:2];
          end
          if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = S_AXI_WDATA;
            wstrb_d  = S_AXI_WSTRB;
          end
          w_state_d = (aw_held_d || w_held_d) ? W_WAIT : W_IDLE;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase

    awready_d = !aw_held_d && !bvalid_d;
    wready_d  = !w_held_d && !bvalid_d;
  end

  // Write channel registers and the RW register array
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state   <= W_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      waddr_idx <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready   <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
      reg_wr    <= '0;
      regs      <= '0;
    end else begin
      w_state   <= w_state_d;
      aw_held   <= aw_held_d;
      w_held    <= w_held_d;
      waddr_idx <= waddr_idx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready   <= awready_d;
      wready    <= wready_d;
      bvalid    <= bvalid_d;
      bresp     <= bresp_d;
      reg_wr    <= reg_wr_d;
      regs      <= regs_d;
    end
  end

  // Read FSM: capture data at the AR handshake and hold it until RREADY
  always_comb begin
    r_state_d = r_state;
    arready_d = arready;
    rvalid_d  = rvalid;
    rdata_d   = rdata;
    rresp_d   = rresp;
    ar_hs     = S_AXI_ARVALID && arready;
    ar_idx    = S_AXI_ARADDR[4:2];

    case (r_state)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          r_state_d = R_RESP;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rresp_d   = is_mapped(ar_idx) ? RESP_OKAY : RESP_SLVERR;
          case (ar_idx)
            REG_STATUS:  rdata_d = status_i;
            REG_VERSION: rdata_d = VERSION;
            default:     rdata_d = is_rw(ar_idx) ? regs[ar_idx[1:0]] : '0;
          endcase
        end
      end
      R_RESP: begin
        if (S_AXI_RREADY) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read channel registers
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      r_state <= r_state_d;
      arready <= arready_d;
      rvalid  <= rvalid_d;
      rdata   <= rdata_d;
      rresp   <= rresp_d;
    end
  end

  // Protection bits and byte-offset bits carry no meaning for this block
  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], wstrb_q};

  assign S_AXI_AWREADY = awready;
  assign S_AXI_WREADY  = wready;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = bresp;
  assign S_AXI_ARREADY = arready;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_RRESP   = rresp;
  assign ctrl_o        = regs[REG_CTRL[1:0]];
  assign target_o      = regs[REG_TARGET[1:0]];
  assign period_o      = regs[REG_PERIOD[1:0]];
  assign accel_o       = regs[REG_ACCEL[1:0]];
  assign reg_wr_o      = reg_wr;

endmodule
